// File: rtl/regfile_access_ctrl.sv
// Operand-read sequencer with a one-entry writeback buffer in front of a registered-read register file.
// Optional macro FWD_BYPASS_EN: writes drain in every state and in-flight writes are forwarded into op_a/op_b.

module regfile_access_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   // operand-read request
   input  logic        iss_valid,
   output logic        iss_ready,
   input  logic [3:0]  iss_ra,
   input  logic [3:0]  iss_rb,
   // operand result
   output logic        op_valid,
   input  logic        op_ready,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   // writeback request
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [3:0]  wb_rd,
   input  logic [15:0] wb_data,
   // register-file side
   output logic        rf_en_read,
   output logic [3:0]  rf_ra_addr,
   output logic [3:0]  rf_rb_addr,
   input  logic [15:0] rf_ra,
   input  logic [15:0] rf_rb,
   output logic        rf_en_write,
   output logic [3:0]  rf_rd_addr,
   output logic [15:0] rf_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WAIT  = 2'd2,
      S_VALID = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   // lane 0 carries the A operand, lane 1 the B operand
   logic [3:0]  r_src_q    [2];
   logic [15:0] r_op       [2];
   logic [3:0]  w_iss_addr [2];
   logic [15:0] w_rf_val   [2];
   logic [15:0] w_op_src   [2];

   logic        r_wbuf_valid;
   logic [3:0]  r_wbuf_rd;
   logic [15:0] r_wbuf_data;

   logic        w_drain;
   logic        w_wr_commit;
   logic        w_wb_accept;
   logic        w_iss_accept;
   logic        w_capture;

   assign w_iss_addr[0] = iss_ra;
   assign w_iss_addr[1] = iss_rb;
   assign w_rf_val[0]   = rf_ra;
   assign w_rf_val[1]   = rf_rb;

   // ---------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      iss_ready    = 1'b0;
      op_valid     = 1'b0;
      rf_en_read   = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: begin
            iss_ready = 1'b1;
            if (iss_valid) begin
               w_state_next = S_READ;
            end
         end
         S_READ: begin
            rf_en_read   = 1'b1;
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            w_capture    = 1'b1;
            w_state_next = S_VALID;
         end
         S_VALID: begin
            op_valid = 1'b1;
            if (op_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign w_iss_accept = iss_valid && iss_ready;

   // ---------------------------------------------------------------
   // Writeback buffer
   // ---------------------------------------------------------------
`ifdef FWD_BYPASS_EN
   assign w_drain = 1'b1;
`else
   // Hold buffered writes while a read is in flight so the operands see a consistent file.
   assign w_drain = (r_state != S_READ) && (r_state != S_WAIT);
`endif

   assign w_wr_commit = r_wbuf_valid && w_drain;
   assign wb_ready    = !r_wbuf_valid || w_drain;
   assign w_wb_accept = wb_valid && wb_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wbuf_valid <= 1'b0;
         r_wbuf_rd    <= 4'd0;
         r_wbuf_data  <= 16'd0;
      end else if (w_wb_accept) begin
         r_wbuf_valid <= 1'b1;
         r_wbuf_rd    <= wb_rd;
         r_wbuf_data  <= wb_data;
      end else if (w_wr_commit) begin
         r_wbuf_valid <= 1'b0;
      end
   end

   assign rf_en_write = w_wr_commit;
   assign rf_rd_addr  = r_wbuf_rd;
   assign rf_data     = r_wbuf_data;

   // ---------------------------------------------------------------
   // Operand lanes
   // ---------------------------------------------------------------
`ifdef FWD_BYPASS_EN
   logic        r_hit      [2];
   logic        w_live_hit [2];
   logic [15:0] r_byp_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_byp_data <= 16'd0;
      end else if (r_state == S_READ) begin
         r_byp_data <= rf_data;
      end
   end
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi = gi + 1) begin : g_lane
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_src_q[gi] <= 4'd0;
            end else if (w_iss_accept) begin
               r_src_q[gi] <= w_iss_addr[gi];
            end
         end

`ifdef FWD_BYPASS_EN
         // A write committing on the READ edge is missed by the registered read; remember it.
         assign w_live_hit[gi] = rf_en_write && (rf_rd_addr == r_src_q[gi]);

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_hit[gi] <= 1'b0;
            end else if (r_state == S_READ) begin
               r_hit[gi] <= w_live_hit[gi];
            end
         end

         assign w_op_src[gi] = w_live_hit[gi] ? rf_data    :
                               r_hit[gi]      ? r_byp_data :
                                                w_rf_val[gi];
`else
         assign w_op_src[gi] = w_rf_val[gi];
`endif

         // Captured once on leaving WAIT, so later writes never disturb a presented operand.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_op[gi] <= 16'd0;
            end else if (w_capture) begin
               r_op[gi] <= w_op_src[gi];
            end
         end
      end
   endgenerate

   assign rf_ra_addr = r_src_q[0];
   assign rf_rb_addr = r_src_q[1];
   assign op_a       = r_op[0];
   assign op_b       = r_op[1];

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: register-file emulator, transaction-level reference model,
// per-cycle compare plus directed scenarios with hand-computed expectations.
module tb_regfile_access_ctrl;

`ifdef FWD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        iss_valid, iss_ready;
   logic [3:0]  iss_ra, iss_rb;
   logic        op_valid, op_ready;
   logic [15:0] op_a, op_b;
   logic        wb_valid, wb_ready;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;
   logic        rf_en_read;
   logic [3:0]  rf_ra_addr, rf_rb_addr;
   logic [15:0] rf_ra = 16'h0000;
   logic [15:0] rf_rb = 16'h0000;
   logic        rf_en_write;
   logic [3:0]  rf_rd_addr;
   logic [15:0] rf_data;

   always #5 clk = ~clk;

   regfile_access_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_ra(iss_ra), .iss_rb(iss_rb),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .rf_en_read(rf_en_read), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
      .rf_ra(rf_ra), .rf_rb(rf_rb),
      .rf_en_write(rf_en_write), .rf_rd_addr(rf_rd_addr), .rf_data(rf_data)
   );

   // Register file emulator: registered read, write-commit on edge, read-during-write returns old data.
   logic [15:0] rf_mem [16] = '{16'h0000, 16'h1001, 16'h1002, 16'h1234, 16'h1004, 16'h1005, 16'h1006, 16'h1007,
                                16'h1008, 16'h1009, 16'h100A, 16'h100B, 16'h100C, 16'h100D, 16'h100E, 16'h100F};
   always @(posedge clk) begin
      if (rf_en_write) rf_mem[rf_rd_addr] <= rf_data;
      if (rf_en_read) begin
         rf_ra <= rf_mem[rf_ra_addr];
         rf_rb <= rf_mem[rf_rb_addr];
      end
   end

   // Reference model: phase counts cycles since issue (0 idle, 1..2 in flight, 3 presenting).
   // Operands equal the register contents including every write committed up to the presenting edge.
   logic [15:0] m_mem [16] = '{16'h0000, 16'h1001, 16'h1002, 16'h1234, 16'h1004, 16'h1005, 16'h1006, 16'h1007,
                               16'h1008, 16'h1009, 16'h100A, 16'h100B, 16'h100C, 16'h100D, 16'h100E, 16'h100F};
   int          m_phase;
   logic [3:0]  m_ra, m_rb, m_buf_rd;
   logic        m_buf_v;
   logic [15:0] m_buf_data, m_op_a, m_op_b;
   logic        e_iss_ready, e_op_valid, e_rf_en_read, e_drain, e_wr, e_wb_ready;

   always_comb begin
      e_iss_ready  = (m_phase == 0);
      e_op_valid   = (m_phase == 3);
      e_rf_en_read = (m_phase == 1);
      e_drain      = BYP || !(m_phase == 1 || m_phase == 2);
      e_wr         = m_buf_v && e_drain;
      e_wb_ready   = !m_buf_v || e_drain;
   end

   function automatic logic [15:0] newest(input logic [3:0] r);
      return (e_wr && m_buf_rd == r) ? m_buf_data : m_mem[r];
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase <= 0; m_ra <= 4'd0; m_rb <= 4'd0;
         m_buf_v <= 1'b0; m_buf_rd <= 4'd0; m_buf_data <= 16'd0;
         m_op_a <= 16'd0; m_op_b <= 16'd0;
      end else begin
         if (e_wr) m_mem[m_buf_rd] <= m_buf_data;
         if (wb_valid && e_wb_ready) begin
            m_buf_v <= 1'b1; m_buf_rd <= wb_rd; m_buf_data <= wb_data;
         end else if (e_wr) begin
            m_buf_v <= 1'b0;
         end
         case (m_phase)
            0: if (iss_valid) begin m_phase <= 1; m_ra <= iss_ra; m_rb <= iss_rb; end
            1: m_phase <= 2;
            2: begin m_phase <= 3; m_op_a <= newest(m_ra); m_op_b <= newest(m_rb); end
            3: if (op_ready) m_phase <= 0;
            default: m_phase <= 0;
         endcase
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int rd_pulses = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk1("iss_ready", iss_ready, e_iss_ready);
      chk1("op_valid", op_valid, e_op_valid);
      chk1("rf_en_read", rf_en_read, e_rf_en_read);
      chk1("wb_ready", wb_ready, e_wb_ready);
      chk1("rf_en_write", rf_en_write, e_wr);
      chk16("op_a", op_a, m_op_a);
      chk16("op_b", op_b, m_op_b);
      chk16("rf_rd_addr", {12'h000, rf_rd_addr}, {12'h000, m_buf_rd});
      chk16("rf_data", rf_data, m_buf_data);
      if (m_phase == 1) begin
         chk16("rf_ra_addr", {12'h000, rf_ra_addr}, {12'h000, m_ra});
         chk16("rf_rb_addr", {12'h000, rf_rb_addr}, {12'h000, m_rb});
      end
   endtask

   // One cycle: compare on the falling edge, return 1 time unit after the next rising edge.
   task automatic tick();
      @(negedge clk);
      if (rf_en_read === 1'b1) rd_pulses++;
      compare_all();
      @(posedge clk);
      #1;
   endtask

   task automatic start_issue(input logic [3:0] ra, input logic [3:0] rb, input logic rdy);
      iss_valid = 1'b1; iss_ra = ra; iss_rb = rb; op_ready = rdy;
      tick();
      iss_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (op_valid !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      chk1("op_valid_seen", op_valid, 1'b1);
      $display("[TB] op ra=%0d rb=%0d a=%h b=%h lat=%0d", m_ra, m_rb, op_a, op_b, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [3:0]  exp_rd;
      logic [15:0] exp_d;

      reset_n = 1'b0; iss_valid = 1'b0; iss_ra = 4'd0; iss_rb = 4'd0; op_ready = 1'b0;
      wb_valid = 1'b0; wb_rd = 4'd0; wb_data = 16'd0;
      #2;
      chk1("rst_op_valid", op_valid, 1'b0);
      chk1("rst_iss_ready", iss_ready, 1'b1);
      chk16("rst_op_a", op_a, 16'h0000);
      chk1("rst_rf_en_write", rf_en_write, 1'b0);
      chk1("rst_rf_en_read", rf_en_read, 1'b0);
      tick(); tick();
      reset_n = 1'b1;

      // Basic read: R3 and R0, three edges counting the handshake edge, one read pulse.
      rd_pulses = 0;
      start_issue(4'd3, 4'd0, 1'b1);
      wait_valid(lat);
      chk16("s1_latency", 16'(lat), 16'd3);
      chk16("s1_op_a", op_a, 16'h1234);
      chk16("s1_op_b", op_b, 16'h0000);
      chk16("s1_rd_pulses", 16'(rd_pulses), 16'd1);
      tick();
      chk1("s1_back_idle", iss_ready, 1'b1);

      // Issue and writeback accepted on the same IDLE edge.
      iss_valid = 1'b1; iss_ra = 4'd5; iss_rb = 4'd2; op_ready = 1'b1;
      wb_valid = 1'b1; wb_rd = 4'd5; wb_data = 16'hBEEF;
      chk1("s2_both_ready", iss_ready && wb_ready, 1'b1);
      tick();
      iss_valid = 1'b0; wb_valid = 1'b0;
      wait_valid(lat);
      chk16("s2_op_a", op_a, BYP ? 16'hBEEF : 16'h1005);
      chk16("s2_op_b", op_b, 16'h1002);
      tick();

      // Write to the read register buffered while the read is in flight.
      start_issue(4'd7, 4'd1, 1'b0);
      wb_valid = 1'b1; wb_rd = 4'd7; wb_data = 16'h00FF;
      tick();
      chk1("s3_wait_wr", rf_en_write, BYP);
      chk1("s3_wait_wb_ready", wb_ready, BYP);
      wb_rd = 4'd8; wb_data = 16'h5555;
      tick();
      chk1("s3_valid", op_valid, 1'b1);
      chk16("s3_op_a", op_a, BYP ? 16'h00FF : 16'h1007);
      chk16("s3_op_b", op_b, 16'h1001);
      chk1("s3_valid_wr", rf_en_write, 1'b1);
      tick();
      wb_valid = 1'b0; op_ready = 1'b1;
      tick();
      start_issue(4'd7, 4'd8, 1'b1);
      wait_valid(lat);
      chk16("s3_r7", op_a, 16'h00FF);
      chk16("s3_r8", op_b, 16'h5555);
      tick();

      // Backpressure in VALID while R1 is overwritten: operands stay a snapshot.
      start_issue(4'd1, 4'd3, 1'b0);
      wait_valid(lat);
      wb_valid = 1'b1; wb_rd = 4'd1; wb_data = 16'hAAAA;
      for (int i = 0; i < 5; i++) begin
         tick();
         wb_valid = 1'b0;
         chk16("s4_hold_a", op_a, 16'h1001);
         chk1("s4_hold_iss_ready", iss_ready, 1'b0);
      end
      op_ready = 1'b1;
      tick();
      chk1("s4_idle", iss_ready, 1'b1);
      start_issue(4'd1, 4'd1, 1'b1);
      wait_valid(lat);
      chk16("s4_new_r1", op_a, 16'hAAAA);
      tick();

      // Reset in WAIT with a write buffered.
      start_issue(4'd2, 4'd4, 1'b1);
      wb_valid = 1'b1; wb_rd = 4'd2; wb_data = 16'h7777;
      tick();
      wb_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      chk1("s5_op_valid", op_valid, 1'b0);
      chk16("s5_op_a", op_a, 16'h0000);
      chk16("s5_op_b", op_b, 16'h0000);
      chk1("s5_rf_en_write", rf_en_write, 1'b0);
      chk1("s5_rf_en_read", rf_en_read, 1'b0);
      chk16("s5_rf_data", rf_data, 16'h0000);
      chk16("s5_rf_ra_addr", {12'h000, rf_ra_addr}, 16'h0000);
      tick();
      reset_n = 1'b1;
      chk1("s5_ready_after_rst", iss_ready, 1'b1);
      rd_pulses = 0;
      start_issue(4'd2, 4'd4, 1'b1);
      wait_valid(lat);
      chk16("s5_latency", 16'(lat), 16'd3);
      chk16("s5_r2_unwritten", op_a, 16'h1002);
      chk16("s5_r4", op_b, 16'h1004);
      tick();

      // Back-to-back writebacks with no issue.
      for (int i = 0; i < 6; i++) begin
         wb_valid = 1'b1; wb_rd = 4'(8 + i); wb_data = 16'(16'hC000 + i);
         tick();
         exp_rd = 4'(8 + i);
         exp_d  = 16'(16'hC000 + i);
         $display("[TB] wb rd=%0d data=%h", exp_rd, exp_d);
         chk1("s6_wr", rf_en_write, 1'b1);
         chk1("s6_wb_ready", wb_ready, 1'b1);
         chk16("s6_rd_addr", {12'h000, rf_rd_addr}, {12'h000, exp_rd});
         chk16("s6_data", rf_data, exp_d);
      end
      wb_valid = 1'b0;
      start_issue(4'd9, 4'd13, 1'b1);
      wait_valid(lat);
      chk16("s6_r9", op_a, 16'hC001);
      chk16("s6_r13", op_b, 16'hC005);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
